cd_to_ab_rx: RTL and testbench



---
 rtl/cd_to_ab_rx.sv | 58 +++++
 tb/tb_cd_to_ab_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cd_to_ab_rx.sv
// cd_to_ab_rx: clkAB-side receiver of a 4-phase req/ack handshake from clkCD, buffering words in a show-ahead FIFO.
module cd_to_ab_rx #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clkAB,
  input  logic                       rst,
  input  logic                       req_cd,
  input  logic [WIDTH-1:0]           data_cd,
  output logic                       ack_ab,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic req_s, push, pop;
  assign req_s = sync[SYNC_STAGES-1];
  assign full = count == CW'(DEPTH);
  assign dout_valid = count != '0;
  assign dout = mem[rd_ptr];
  assign pop = dout_valid && dout_ready;
  always_comb begin
    push = state == S_IDLE && req_s && !full;
    state_n = state == S_INIT ? (req_s ? S_INIT : S_IDLE) :
              state == S_IDLE ? (push ? S_ACK : S_IDLE) :
              (req_s ? S_ACK : S_IDLE);
  end
  // Chain resets high so a req still asserted across reset is never mistaken for a fresh request.
  always_ff @(posedge clkAB) begin
    if (rst) begin
      sync <= '1;
      state <= S_INIT;
      ack_ab <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_cd};
      state <= state_n;
      ack_ab <= state_n == S_ACK;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clkAB) begin
    if (push) mem[wr_ptr] <= data_cd;
  end
endmodule

// File: tb/tb_cd_to_ab_rx.sv
// tb_cd_to_ab_rx: directed and randomized checks of cd_to_ab_rx against a cycle-level queue model.
module tb_cd_to_ab_rx;
  localparam int WIDTH = 2, DEPTH = 4, SS = 2, CW = $clog2(DEPTH+1);
  logic clkAB = 1'b0, rst = 1'b1, req_cd = 1'b0, dout_ready = 1'b0;
  logic [WIDTH-1:0] data_cd = '0;
  logic ack_ab, dout_valid, full;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0] count;
  int tests = 0, fails = 0;
  int q[$];
  int hist[$];
  bit mack = 1'b0, armed = 1'b0;
  int exp_o[4] = '{1, 2, 3, 3};

  cd_to_ab_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clkAB(clkAB), .rst(rst), .req_cd(req_cd), .data_cd(data_cd), .ack_ab(ack_ab),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .count(count), .full(full)
  );

  always #5 clkAB = ~clkAB;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // req_s used at an edge is req_cd as sampled SS edges earlier; the model arms once it sees req_s low.
  task automatic step();
    bit r, rdy, rs, pu, po;
    int d;
    r = req_cd;
    rdy = dout_ready;
    d = int'(data_cd);
    @(posedge clkAB);
    if (rst) begin
      q.delete();
      hist.delete();
      repeat (SS) hist.push_back(1);
      mack = 1'b0;
      armed = 1'b0;
    end else begin
      rs = hist.pop_front() != 0;
      hist.push_back(int'(r));
      po = rdy && q.size() > 0;
      pu = !mack && armed && rs && q.size() < DEPTH;
      if (mack) begin
        if (!rs) begin
          mack = 1'b0;
          armed = 1'b1;
        end
      end else if (!armed) armed = !rs;
      else if (pu) mack = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
    #1;
    check("ack", ack_ab, mack);
    check("count", count, q.size());
    check("valid", dout_valid, q.size() != 0);
    check("full", full, q.size() == DEPTH);
    if (q.size() != 0) check("dout", dout, q[0]);
  endtask

  task automatic wait_ack(bit v);
    for (int i = 0; i < 40 && ack_ab !== v; i++) step();
    check("wait_ack", ack_ab, v);
  endtask

  task automatic send(int d);
    data_cd = WIDTH'(d);
    req_cd = 1'b1;
    wait_ack(1'b1);
    req_cd = 1'b0;
    wait_ack(1'b0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_ack", ack_ab, 0);
    check("rst_count", count, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_full", full, 0);
    repeat (3) step();
    data_cd = 2'b10;
    req_cd = 1'b1;
    step();
    check("single_e1", ack_ab, 0);
    step();
    check("single_e2", ack_ab, 0);
    step();
    check("single_ack", ack_ab, 1);
    check("single_dout", dout, 2);
    check("single_count", count, 1);
    check("single_valid", dout_valid, 1);
    req_cd = 1'b0;
    step();
    step();
    check("drop_e2", ack_ab, 1);
    step();
    check("drop_ack", ack_ab, 0);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("single_empty", dout_valid, 0);
    for (int i = 0; i < 4; i++) send(i);
    check("b2b_count", count, 4);
    check("b2b_full", full, 1);
    check("b2b_head", dout, 0);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_order", dout, i);
      step();
    end
    dout_ready = 1'b0;
    check("b2b_empty", dout_valid, 0);
    for (int i = 0; i < 4; i++) send(i);
    data_cd = 2'b11;
    req_cd = 1'b1;
    repeat (10) step();
    check("ovf_stall", ack_ab, 0);
    check("ovf_count", count, 4);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    wait_ack(1'b1);
    check("ovf_refill", count, 4);
    req_cd = 1'b0;
    wait_ack(1'b0);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", dout, exp_o[i]);
      step();
    end
    dout_ready = 1'b0;
    send(1);
    send(2);
    data_cd = 2'b00;
    req_cd = 1'b1;
    step();
    step();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("pp_ack", ack_ab, 1);
    check("pp_count", count, 2);
    check("pp_head", dout, 2);
    req_cd = 1'b0;
    wait_ack(1'b0);
    dout_ready = 1'b1;
    repeat (3) step();
    dout_ready = 1'b0;
    data_cd = 2'b01;
    req_cd = 1'b1;
    wait_ack(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ack", ack_ab, 0);
    check("mid_rst_count", count, 0);
    repeat (8) step();
    check("mid_hold_ack", ack_ab, 0);
    check("mid_hold_count", count, 0);
    req_cd = 1'b0;
    repeat (4) step();
    req_cd = 1'b1;
    wait_ack(1'b1);
    check("mid_once", count, 1);
    req_cd = 1'b0;
    wait_ack(1'b0);
    for (int i = 0; i < 600; i++) begin
      rst = i == 300;
      if (!req_cd && !ack_ab && $urandom_range(0, 2) == 0) begin
        data_cd = WIDTH'($urandom);
        req_cd = 1'b1;
      end else if (req_cd && ack_ab && $urandom_range(0, 1) == 1) req_cd = 1'b0;
      dout_ready = i < 300 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
